// File: rtl/uart_txrx_param_if.sv
// Bus-side handshake bundle for uart_txrx_param: TX request/status and RX result.
// master = on-chip bus side, slave = UART engine.
interface uart_txrx_param_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  tx_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_parity_err;
    logic                  rx_frame_err;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_txrx_param.sv
// uart_txrx_param: parametrised full-duplex UART, run-time baud select, 16x oversampled RX
// with parity and framing error reporting.
// Optional feature: define UART_LOOPBACK_EN to feed RX from the internal TX line
// (uart_rxd ignored, uart_txd held high).
module uart_txrx_param #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        baud_sel,
    output logic              uart_txd,
    input  logic              uart_rxd,
    uart_txrx_param_if.slave  bus
);

    function automatic int unsigned baud_div(input int unsigned baud);
        int unsigned d;
        d = (CLK_FREQ_HZ + baud * 8) / (baud * 16);
        return (d == 0) ? 1 : d;
    endfunction

    localparam int unsigned DIV_1200   = baud_div(1200);
    localparam int unsigned DIV_2400   = baud_div(2400);
    localparam int unsigned DIV_4800   = baud_div(4800);
    localparam int unsigned DIV_9600   = baud_div(9600);
    localparam int unsigned DIV_19200  = baud_div(19200);
    localparam int unsigned DIV_38400  = baud_div(38400);
    localparam int unsigned DIV_57600  = baud_div(57600);
    localparam int unsigned DIV_115200 = baud_div(115200);
    localparam int unsigned DIV_230400 = baud_div(230400);
    localparam int unsigned CW         = $clog2(DIV_1200 + 1);

    localparam logic [3:0] LAST_DATA  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY_MODE != 0);
    localparam logic       ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic [CW-1:0] div_sel, div_d, div_q;
    logic [CW-1:0] tx_cnt_d, tx_cnt_q, rx_cnt_d, rx_cnt_q;
    logic          tx_tick, rx_tick, tx_active, rx_run, tx_bit_end, rx_sample;

    logic [DATA_WIDTH-1:0] tx_shift_d, tx_shift_q;
    logic [3:0]            tx_sub_d, tx_sub_q, tx_bit_d, tx_bit_q;
    logic                  tx_par_d, tx_par_q, tx_done_d, tx_done_q, tx_ser;

    logic                  rx_meta_q, rx_sync_q, rx_src;
    logic [DATA_WIDTH-1:0] rx_shift_d, rx_shift_q, rx_data_d, rx_data_q;
    logic [3:0]            rx_sub_d, rx_sub_q, rx_bit_d, rx_bit_q;
    logic                  rx_parbit_d, rx_parbit_q, rx_valid_d, rx_valid_q;
    logic                  rx_perr_d, rx_perr_q, rx_ferr_d, rx_ferr_q;

`ifdef UART_LOOPBACK_EN
    assign rx_src   = tx_ser;
    assign uart_txd = 1'b1;
`else
    assign rx_src   = uart_rxd;
    assign uart_txd = tx_ser;
`endif

    assign tx_active  = (tx_state_q != TX_IDLE);
    assign rx_run     = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                        (rx_state_q == RX_PARITY) || (rx_state_q == RX_STOP);
    assign tx_bit_end = tx_tick && (tx_sub_q == 4'd15);
    assign rx_sample  = rx_tick && ((rx_state_q == RX_START) ? (rx_sub_q == 4'd7)
                                                            : (rx_sub_q == 4'd15));

    assign bus.tx_busy       = tx_active;
    assign bus.tx_done       = tx_done_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;

    // Divisor lookup; re-latched only while both engines are idle
    always_comb begin
        case (baud_sel)
            4'd0:    div_sel = CW'(DIV_1200);
            4'd1:    div_sel = CW'(DIV_2400);
            4'd2:    div_sel = CW'(DIV_4800);
            4'd3:    div_sel = CW'(DIV_9600);
            4'd4:    div_sel = CW'(DIV_19200);
            4'd5:    div_sel = CW'(DIV_38400);
            4'd6:    div_sel = CW'(DIV_57600);
            4'd7:    div_sel = CW'(DIV_115200);
            4'd8:    div_sel = CW'(DIV_230400);
            default: div_sel = CW'(DIV_9600);
        endcase
        div_d = (!tx_active && rx_state_q == RX_IDLE) ? div_sel : div_q;
    end

    // Tick phase per engine: held at zero while idle so bit edges align to the frame start
    always_comb begin
        tx_tick  = tx_active && (tx_cnt_q == div_q - 1'b1);
        rx_tick  = rx_run && (rx_cnt_q == div_q - 1'b1);
        tx_cnt_d = (!tx_active || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        rx_cnt_d = (!rx_run || rx_tick) ? '0 : rx_cnt_q + 1'b1;
    end

    // Divisor, tick counters and RX input synchroniser
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q     <= CW'(DIV_9600);
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_meta_q <= rx_src;
            rx_sync_q <= rx_meta_q;
        end
    end

    // TX state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_state_q <= TX_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    // TX next state
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:   if (bus.tx_start) tx_state_d = TX_START;
            TX_START:  if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit_q == LAST_DATA)
                           tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    // TX serial output
    always_comb begin
        case (tx_state_q)
            TX_START:  tx_ser = 1'b0;
            TX_DATA:   tx_ser = tx_shift_q[0];
            TX_PARITY: tx_ser = tx_par_q;
            default:   tx_ser = 1'b1;
        endcase
    end

    // TX datapath: word latch, shift, tick/bit counters, done pulse
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_bit_d   = tx_bit_q;
        tx_sub_d   = tx_sub_q;
        if (!tx_active) begin
            tx_sub_d = '0;
            tx_bit_d = '0;
            if (bus.tx_start) begin
                tx_shift_d = bus.tx_data;
                tx_par_d   = (^bus.tx_data) ^ ODD_PARITY;
            end
        end else if (tx_tick) begin
            tx_sub_d = tx_sub_q + 4'd1;
            if (tx_bit_end) begin
                tx_bit_d = (tx_state_d != tx_state_q) ? 4'd0 : tx_bit_q + 4'd1;
                if (tx_state_q == TX_DATA) tx_shift_d = tx_shift_q >> 1;
            end
        end
        tx_done_d = (tx_state_q == TX_STOP) && (tx_state_d == TX_IDLE);
    end

    // TX datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_bit_q   <= '0;
            tx_sub_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_bit_q   <= tx_bit_d;
            tx_sub_q   <= tx_sub_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // RX state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_state_q <= RX_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    // RX next state; a low stop bit parks in RX_WAIT until the line returns high
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:   if (!rx_sync_q) rx_state_d = RX_START;
            RX_START:  if (rx_sample) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_q == LAST_DATA)
                           rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_d = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
            RX_WAIT:   if (rx_sync_q) rx_state_d = RX_IDLE;
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    // RX datapath and result outputs
    always_comb begin
        rx_shift_d  = rx_shift_q;
        rx_parbit_d = rx_parbit_q;
        rx_bit_d    = rx_bit_q;
        rx_sub_d    = rx_sub_q;
        rx_data_d   = rx_data_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        rx_valid_d  = 1'b0;
        if (!rx_run) begin
            rx_sub_d = '0;
            rx_bit_d = '0;
        end else if (rx_tick) begin
            rx_sub_d = rx_sample ? 4'd0 : rx_sub_q + 4'd1;
            if (rx_sample) begin
                rx_bit_d = (rx_state_d != rx_state_q) ? 4'd0 : rx_bit_q + 4'd1;
                case (rx_state_q)
                    RX_DATA:   rx_shift_d  = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    RX_PARITY: rx_parbit_d = rx_sync_q;
                    RX_STOP: begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = HAS_PARITY &&
                                     (rx_parbit_q != ((^rx_shift_q) ^ ODD_PARITY));
                        rx_ferr_d  = !rx_sync_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RX datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_shift_q  <= '0;
            rx_parbit_q <= 1'b0;
            rx_bit_q    <= '0;
            rx_sub_q    <= '0;
            rx_data_q   <= '0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            rx_parbit_q <= rx_parbit_d;
            rx_bit_q    <= rx_bit_d;
            rx_sub_q    <= rx_sub_d;
            rx_data_q   <= rx_data_d;
            rx_perr_q   <= rx_perr_d;
            rx_ferr_q   <= rx_ferr_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_uart_txrx_param.sv
// Directed bench for uart_txrx_param: one 100 MHz 8N1 instance for exact TX bit timing,
// plus two instances on a slow clock (19200 baud -> 256-cycle bits) for RX, 8N1 and 8E1.
module tb_uart_txrx_param;
    localparam int BIT_A = 5216;
    localparam int BIT_F = 256;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] baud_a = 4'd4, baud_b = 4'd4, baud_c = 4'd4;
    logic       txd_a, txd_b, txd_c;
    logic       rxd_a = 1'b1;
    logic       ser = 1'b1;
    logic [9:0] frame_a;
    int checks = 0, errors = 0;
    int vcnt_b = 0, vcnt_c = 0, dcnt_a = 0, dcnt_b = 0, txd_b_low = 0;
    int v0, d0;

    uart_txrx_param_if #(.DATA_WIDTH(8)) bus_a ();
    uart_txrx_param_if #(.DATA_WIDTH(8)) bus_b ();
    uart_txrx_param_if #(.DATA_WIDTH(8)) bus_c ();

    uart_txrx_param #(.CLK_FREQ_HZ(100000000), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1))
        dut_a (.clock(clock), .reset(reset), .baud_sel(baud_a), .uart_txd(txd_a),
               .uart_rxd(rxd_a), .bus(bus_a));
    uart_txrx_param #(.CLK_FREQ_HZ(4915200), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1))
        dut_b (.clock(clock), .reset(reset), .baud_sel(baud_b), .uart_txd(txd_b),
               .uart_rxd(ser), .bus(bus_b));
    uart_txrx_param #(.CLK_FREQ_HZ(4915200), .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1))
        dut_c (.clock(clock), .reset(reset), .baud_sel(baud_c), .uart_txd(txd_c),
               .uart_rxd(ser), .bus(bus_c));

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle
    always @(negedge clock) begin
        if (bus_b.rx_valid) vcnt_b++;
        if (bus_c.rx_valid) vcnt_c++;
        if (bus_a.tx_done)  dcnt_a++;
        if (bus_b.tx_done)  dcnt_b++;
        if (txd_b === 1'b0) txd_b_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits LSB first on the shared serial line, BIT_F cycles each
    task automatic send_frame(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ser = f[i];
            repeat (BIT_F) @(negedge clock);
        end
    endtask

    initial begin
        bus_a.tx_start = 1'b0; bus_b.tx_start = 1'b0; bus_c.tx_start = 1'b0;
        bus_a.tx_data = '0;    bus_b.tx_data = '0;    bus_c.tx_data = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_txd", txd_a, 1);
        chk("rst_busy", bus_a.tx_busy, 0);
        chk("rst_done", bus_a.tx_done, 0);
        chk("rst_valid", bus_a.rx_valid, 0);
        chk("rst_perr", bus_a.rx_parity_err, 0);
        chk("rst_ferr", bus_a.rx_frame_err, 0);
        chk("rst_rxdata", bus_a.rx_data, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("rel_txd", txd_a, 1);
        chk("rel_busy", bus_a.tx_busy, 0);

`ifdef UART_LOOPBACK_EN
        bus_b.tx_data = 8'h3C; bus_b.tx_start = 1'b1;
        @(negedge clock);
        bus_b.tx_start = 1'b0;
        repeat (11 * BIT_F) @(negedge clock);
        chk("lb_done_cnt", dcnt_b, 1);
        chk("lb_valid_cnt", vcnt_b, 1);
        chk("lb_rxdata", bus_b.rx_data, 8'h3C);
        chk("lb_perr", bus_b.rx_parity_err, 0);
        chk("lb_ferr", bus_b.rx_frame_err, 0);
        chk("lb_txd_low_cycles", txd_b_low, 0);
`else
        // 0x5B at 19200 on 100 MHz: 10 bits of 5216 cycles, baud change mid-frame ignored
        frame_a = {1'b1, 8'h5B, 1'b0};
        bus_a.tx_data = 8'h5B; bus_a.tx_start = 1'b1;
        @(posedge clock); #1;
        bus_a.tx_start = 1'b0;
        chk("a_busy_rise", bus_a.tx_busy, 1);
        repeat (BIT_A / 2) @(posedge clock);
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                repeat (BIT_A) @(posedge clock);
                #1;
            end
            chk($sformatf("a_txd_bit%0d", k), txd_a, frame_a[k]);
            if (k == 3) baud_a = 4'd7;
        end
        repeat (BIT_A / 2 - 1) @(posedge clock);
        #1;
        chk("a_done_early", bus_a.tx_done, 0);
        chk("a_busy_early", bus_a.tx_busy, 1);
        @(posedge clock); #1;
        chk("a_done_pulse", bus_a.tx_done, 1);
        chk("a_busy_fall", bus_a.tx_busy, 0);
        chk("a_txd_idle", txd_a, 1);
        @(posedge clock); #1;
        chk("a_done_clear", bus_a.tx_done, 0);
        chk("a_done_cnt", dcnt_a, 1);
        @(negedge clock);

        // RX 8N1 0xA5
        v0 = vcnt_b;
        send_frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (BIT_F) @(negedge clock);
        chk("b_a5_valid_cnt", vcnt_b - v0, 1);
        chk("b_a5_data", bus_b.rx_data, 8'hA5);
        chk("b_a5_perr", bus_b.rx_parity_err, 0);
        chk("b_a5_ferr", bus_b.rx_frame_err, 0);

        // Low stop bit, line held low 3 more bit times, then recovery with a good frame
        v0 = vcnt_b;
        send_frame({6'b0, 1'b0, 8'h81, 1'b0}, 10);
        repeat (3 * BIT_F) @(negedge clock);
        chk("b_brk_valid_cnt", vcnt_b - v0, 1);
        chk("b_brk_ferr", bus_b.rx_frame_err, 1);
        chk("b_brk_data", bus_b.rx_data, 8'h81);
        ser = 1'b1;
        repeat (BIT_F) @(negedge clock);
        chk("b_brk_no_extra", vcnt_b - v0, 1);
        send_frame({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (BIT_F) @(negedge clock);
        chk("b_rec_valid_cnt", vcnt_b - v0, 2);
        chk("b_rec_ferr", bus_b.rx_frame_err, 0);
        chk("b_rec_data", bus_b.rx_data, 8'h3C);

        // 100-cycle glitch in idle is a false start
        v0 = vcnt_b;
        ser = 1'b0;
        repeat (100) @(negedge clock);
        ser = 1'b1;
        repeat (2 * BIT_F) @(negedge clock);
        chk("b_glitch_valid_cnt", vcnt_b - v0, 0);
        chk("b_glitch_data", bus_b.rx_data, 8'h3C);

        // Second tx_start while busy: neither restarts nor queues
        d0 = dcnt_b;
        bus_b.tx_data = 8'hC3; bus_b.tx_start = 1'b1;
        @(negedge clock);
        bus_b.tx_start = 1'b0;
        repeat (3 * BIT_F) @(negedge clock);
        chk("b_tx_busy_mid", bus_b.tx_busy, 1);
        bus_b.tx_data = 8'hFF; bus_b.tx_start = 1'b1;
        @(negedge clock);
        bus_b.tx_start = 1'b0;
        repeat (1900) @(negedge clock);
        chk("b_tx_done_on_time", dcnt_b - d0, 1);
        chk("b_tx_idle_after", bus_b.tx_busy, 0);
        repeat (3000) @(negedge clock);
        chk("b_tx_no_queue", dcnt_b - d0, 1);
        chk("b_txd_idle", txd_b, 1);

        // 8E1: 0x07 needs parity 1; first send 0, then correct
        v0 = vcnt_c;
        send_frame({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (BIT_F) @(negedge clock);
        chk("c_bad_valid_cnt", vcnt_c - v0, 1);
        chk("c_bad_perr", bus_c.rx_parity_err, 1);
        chk("c_bad_ferr", bus_c.rx_frame_err, 0);
        chk("c_bad_data", bus_c.rx_data, 8'h07);
        send_frame({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (BIT_F) @(negedge clock);
        chk("c_good_valid_cnt", vcnt_c - v0, 2);
        chk("c_good_perr", bus_c.rx_parity_err, 0);
        chk("c_good_data", bus_c.rx_data, 8'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_txrx_param.md
Name: uart_txrx_param

Overview:
- Parametrised full-duplex UART engine; next generation of the fixed 8-bit, fixed-baud UART top.
- Data width, parity mode and stop-bit count are set by parameters; baud rate is selected at run time.
- RX uses 16x oversampling and reports parity and framing errors.
- Sits between the serial pins and the on-chip data bus, using the same start-trigger / send-done / receive-done handshake style.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency used to derive baud divisors at elaboration.
- DATA_WIDTH, 8, payload bits per frame; legal 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, TX stop bits; legal 1 or 2. RX checks only the first stop bit.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- baud_sel  in  4  baud select: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200, 8=230400, 9..15=9600.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_start  in  1  request to send, accepted when tx_busy=0.
- tx_busy  out  1  TX frame in progress.
- tx_done  out  1  one-cycle pulse when the last stop bit completes.
- uart_txd  out  1  serial output; idles high.
- uart_rxd  in  1  serial input, asynchronous to clock.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_parity_err  out  1  parity mismatch on the last received word.
- rx_frame_err  out  1  first stop bit sampled low on the last received word.

Behaviour:
- Reset (reset=0, asynchronous): uart_txd=1; tx_busy, tx_done, rx_valid, rx_parity_err, rx_frame_err = 0; rx_data = 0; both FSMs go to IDLE; divisor = entry for baud_sel at reset release.
- Divisor: DIV = round(CLK_FREQ_HZ / (baud*16)), computed as localparams.
  - Tick generator produces a one-cycle tick every DIV clocks.
  - baud_sel is re-latched only when both TX and RX are IDLE; the tick counter restarts on a divisor change.
  - A baud_sel change mid-frame has no effect until both engines are idle.
- Bit timing: every bit lasts exactly 16 ticks.
- TX FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE):
  - tx_start=1 in IDLE latches tx_data; tx_busy rises the next cycle.
  - tx_start while busy is ignored; no queueing.
  - Data is sent LSB first.
  - Parity bit = XOR of the data bits (even mode) or its inverse (odd mode).
  - STOP drives 1 for STOP_BITS bit periods.
  - At the end: tx_done pulses and tx_busy falls in the same cycle; a new tx_start is accepted from the next cycle.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
  - IDLE -> START on synchronised low.
  - START: after 8 ticks, resample; if high it is a false start and the FSM returns to IDLE with no flags set.
  - DATA: sample every 16 ticks (bit centre), shift LSB first.
  - PARITY: sample the parity bit and compare.
  - STOP: sample the first stop bit at its centre. That cycle, rx_valid pulses, rx_data updates and both error flags update.
  - Error flags hold until the next rx_valid.
  - If the stop bit is low (frame error or break), the FSM waits for the line to return high before going to IDLE.
- Simultaneous events: TX and RX are fully independent; a reception and a transmission may complete in the same cycle.
- Reset mid-frame: frame is aborted; uart_txd returns to 1 immediately; no tx_done or rx_valid is issued.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: RX input is taken from the internal TX serial signal; uart_rxd is ignored; uart_txd is held at 1.
- Not defined: RX input is uart_rxd and uart_txd carries TX data.

Test Plan:
- Reset release, baud_sel=4, CLK 100 MHz -> DIV=326, bit time 5216 cycles; uart_txd=1 and all flags 0.
- 8N1, tx_data=0x5B, tx_start for 1 cycle -> uart_txd sequence 0,1,1,0,1,1,0,1,0,1, each bit 5216 cycles; tx_done after 52160 cycles.
- RX 8N1, drive frame for 0xA5 at 19200 -> rx_valid once, rx_data=0xA5, both error flags 0.
- PARITY_MODE=1, drive 0x07 with parity bit 0 -> rx_parity_err=1 with rx_valid; next frame with correct parity clears it.
- Stop bit driven 0, line held low for 3 bit times -> rx_frame_err=1; no new frame until line is high and a new start bit arrives.
- 100-cycle low glitch in IDLE -> no rx_valid. Second tx_start while busy -> ignored, only one frame sent.
- With UART_LOOPBACK_EN defined, send 0x3C -> rx_valid with rx_data=0x3C; uart_txd stays 1.
